// File: rtl/video_timing_gen.sv
// Free-running VGA timing generator: sync, visible-area flag, half-resolution
// coordinates, line/frame pulses and a frame counter, all registered.
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_display_on,
    output logic [8:0] o_hpos,
    output logic [8:0] o_vpos,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Compare constants are 11 bits so a sync end of exactly 1024 still works.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt_reg, h_cnt_next;
    logic [9:0]  v_cnt_reg, v_cnt_next;
    logic [10:0] h_ext, v_ext;
    logic        h_wrap, v_wrap;
    logic        h_vis, v_vis, origin;

    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        display_on_reg, display_on_next;
    logic [8:0]  hpos_reg, hpos_next;
    logic [8:0]  vpos_reg, vpos_next;
    logic        line_start_reg, line_start_next;
    logic        frame_start_reg, frame_start_next;
    logic [7:0]  frame_count_reg, frame_count_next;
    logic        first_frame_reg, first_frame_next;

    assign h_ext = {1'b0, h_cnt_reg};
    assign v_ext = {1'b0, v_cnt_reg};

    always_comb begin
        h_wrap     = (h_ext == H_LAST);
        v_wrap     = (v_ext == V_LAST);
        h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
        end
    end

    always_comb begin
        h_vis  = (h_ext < H_ACT);
        v_vis  = (v_ext < V_ACT);
        origin = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);

        display_on_next  = h_vis && v_vis;
        hpos_next        = h_vis ? h_cnt_reg[9:1] : 9'd0;
        vpos_next        = v_vis ? v_cnt_reg[9:1] : 9'd0;
        hsync_next       = ((h_ext >= HS_START) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_next       = ((v_ext >= VS_START) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
        line_start_next  = (h_cnt_reg == 10'd0);
        frame_start_next = origin;

        // The very first frame after reset keeps count 0; later ones advance it.
        frame_count_next = frame_count_reg;
        first_frame_next = first_frame_reg;
        if (origin) begin
            first_frame_next = 1'b0;
            if (!first_frame_reg) begin
                frame_count_next = frame_count_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg       <= 10'd0;
            v_cnt_reg       <= 10'd0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            display_on_reg  <= 1'b0;
            hpos_reg        <= 9'd0;
            vpos_reg        <= 9'd0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_count_reg <= 8'd0;
            first_frame_reg <= 1'b1;
        end else begin
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            display_on_reg  <= display_on_next;
            hpos_reg        <= hpos_next;
            vpos_reg        <= vpos_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            frame_count_reg <= frame_count_next;
            first_frame_reg <= first_frame_next;
        end
    end

    assign o_hsync       = hsync_reg;
    assign o_vsync       = vsync_reg;
    assign o_display_on  = display_on_reg;
    assign o_hpos        = hpos_reg;
    assign o_vpos        = vpos_reg;
    assign o_line_start  = line_start_reg;
    assign o_frame_start = frame_start_reg;
    assign o_frame_count = frame_count_reg;

endmodule
